tx_byte_fifo: RTL and testbench

// - Byte buffer directly upstream of the transceiver PISO serializer.
// - Absorbs bursts from the host/packet logic.
// - Presents one word at a time to the serializer over a valid/ready handshake.
// - First-word-fall-through: the head word is on m_data whenever m_valid=1.
//   No read-request cycle is needed.
//

---
 rtl/tx_byte_fifo.sv | 156 +++++++++++++++
 tb/tb_tx_byte_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_byte_fifo.sv
// ---------------------------------------------------------------------------
// tx_byte_fifo
//
// Byte buffer that sits directly upstream of the transceiver PISO serializer.
// It absorbs bursts from the host/packet logic and hands one word at a time
// to the serializer over a valid/ready handshake. The FIFO is
// first-word-fall-through: whenever m_valid is high, the head word is already
// on m_data, so no read-request cycle is needed.
//
// Parameters
//   DATA_WIDTH  width of each stored word (serializer data_in width)
//   DEPTH_LOG2  log2 of the storage depth (DEPTH = 2**DEPTH_LOG2)
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous active-high reset; discards all queued words
//   wr_en     in   write request from upstream
//   wr_data   in   word to write
//   full      out  no free entry; a write this cycle is dropped
//   overflow  out  sticky flag: a write was dropped while full
//   ovf_clr   in   one-cycle pulse that clears overflow (a new drop wins)
//   m_valid   out  head word available (serializer valid)
//   m_data    out  head word (serializer data_in)
//   m_ready   in   serializer can take a word this cycle
//
// Optional feature, enabled by defining TX_FIFO_LEVEL_EN:
//   level     out  current fill count, 0..DEPTH
//   afull     out  registered almost-full flag, high when count >= DEPTH-2
// ---------------------------------------------------------------------------
module tx_byte_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef TX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  afull
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE   = (DEPTH_LOG2 + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic wr_acc;
    logic rd_acc;

    // Status flags come straight from the registered count, so they describe
    // the FIFO as it stood at the start of the cycle.
    assign full     = (count_q == FULL_COUNT);
    assign m_valid  = (count_q != '0);
    assign overflow = overflow_q;

    // The head entry can never be overwritten by a concurrent write: when the
    // FIFO is non-empty and not full, wr_ptr differs from rd_ptr, and when it
    // is full the write is refused.
    assign m_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_acc = wr_en & ~full;
        rd_acc = m_valid & m_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // A simultaneous accepted write and read leaves the count unchanged.
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase

        // Evaluated in this order so that a drop in the same cycle as a clear
        // leaves the flag set.
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (wr_en & full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; stale contents are never
    // visible because m_valid gates them and the pointers restart at zero.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef TX_FIFO_LEVEL_EN
    localparam logic [DEPTH_LOG2:0] AFULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH - 2);

    logic afull_q, afull_d;

    // afull is computed from the next count so it changes on the same edge
    // as count itself.
    always_comb begin
        afull_d = (count_d >= AFULL_COUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign level = count_q;
    assign afull = afull_q;
`endif

endmodule

// File: tb/tb_tx_byte_fifo.sv
// ---------------------------------------------------------------------------
// tb_tx_byte_fifo
//
// Scoreboard bench for tx_byte_fifo. The driver owns a queue-based reference
// model of the FIFO: every cycle it records the expected status flags and
// pushes each word the FIFO should accept onto an expected-data queue. An
// independent monitor samples the DUT mid-cycle, compares the status flags,
// checks the presented head word against the front of the expected-data
// queue and pops it when the serializer handshake completes.
// ---------------------------------------------------------------------------
module tb_tx_byte_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                  clk;
    logic                  rst;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  overflow;
    logic                  ovf_clr;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;
`ifdef TX_FIFO_LEVEL_EN
    logic [DEPTH_LOG2:0]   level;
    logic                  afull;
`endif

    tx_byte_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready)
`ifdef TX_FIFO_LEVEL_EN
        ,
        .level    (level),
        .afull    (afull)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic     valid;
        logic     full;
        logic     ovf;
        int       level;
        logic     afull;
        logic     flush;
    } status_t;

    status_t               status_q[$];
    logic [DATA_WIDTH-1:0] data_q[$];

    int model_count;
    logic model_ovf;

    int vectors;
    int miscompares;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; updates the reference model for that cycle.
    task automatic applyStimulus(input logic we, input logic [DATA_WIDTH-1:0] wd,
                                 input logic mr, input logic oc, input logic r);
        status_t st;
        logic    wacc;
        logic    racc;
        @(posedge clk);
        #2;
        wr_en   = we;
        wr_data = wd;
        m_ready = mr;
        ovf_clr = oc;
        rst     = r;

        st.valid = (model_count != 0);
        st.full  = (model_count == DEPTH);
        st.ovf   = model_ovf;
        st.level = model_count;
        st.afull = (model_count >= DEPTH - 2);
        st.flush = r;
        status_q.push_back(st);

        if (r) begin
            model_count = 0;
            model_ovf   = 1'b0;
        end else begin
            wacc = we && (model_count < DEPTH);
            racc = mr && (model_count > 0);
            if (we && model_count == DEPTH) begin
                model_ovf = 1'b1;
            end else if (oc) begin
                model_ovf = 1'b0;
            end
            if (wacc) begin
                data_q.push_back(wd);
            end
            model_count = model_count + int'(wacc) - int'(racc);
        end
    endtask

    // Mid-cycle sample of the DUT against the scoreboard.
    task automatic checkOutput();
        status_t st;
        @(negedge clk);
        if (status_q.size() == 0) begin
            return;
        end
        st = status_q.pop_front();
        compare("m_valid", 32'(m_valid), 32'(st.valid));
        compare("full", 32'(full), 32'(st.full));
        compare("overflow", 32'(overflow), 32'(st.ovf));
`ifdef TX_FIFO_LEVEL_EN
        compare("level", 32'(level), 32'(st.level));
        compare("afull", 32'(afull), 32'(st.afull));
`endif
        if (m_valid === 1'b1) begin
            if (data_q.size() == 0) begin
                compare("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                compare("m_data", 32'(m_data), 32'(data_q[0]));
                if (m_ready) begin
                    void'(data_q.pop_front());
                end
            end
        end
        if (st.flush) begin
            data_q.delete();
        end
    endtask

    initial begin
        forever checkOutput();
    end

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, mr, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int phase_wr;
        int phase_rd;

        vectors     = 0;
        miscompares = 0;
        model_count = 0;
        model_ovf   = 1'b0;
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        m_ready     = 1'b0;
        ovf_clr     = 1'b0;

        // Reset then idle
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Single word held while the serializer is busy, then taken
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Fill to full, drop a 17th word, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle(DEPTH + 2, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Write and read together while full, then drop-versus-clear race
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        applyStimulus(1'b1, 8'h90, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(DEPTH + 2, 1'b1);

        // Streaming at one word per cycle across pointer wrap
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        end
        idle(3, 1'b1);

        // Reset mid-drain discards everything
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        end
        idle(2, 1'b1);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic with shifting write/read pressure
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) begin
                phase_wr = $urandom_range(20, 95);
                phase_rd = $urandom_range(10, 95);
            end
            applyStimulus(($urandom_range(0, 99) < phase_wr),
                          8'($urandom_range(0, 255)),
                          ($urandom_range(0, 99) < phase_rd),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 249) == 0));
        end

        // Bounded drain, then confirm the scoreboard emptied
        idle(DEPTH + 4, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        compare("leftover_words", 32'(data_q.size()), 32'd0);
        compare("leftover_status", 32'(status_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
